// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: operand selects, forward selects,
// the latched ID/EX record and its bubble value.
package ex_operand_stage_pkg;

  // Widths of the latched record; the top-level XLEN/REG_AW must equal these.
  localparam int EX_XLEN   = 32;
  localparam int EX_REG_AW = 5;

  localparam logic [3:0] ALU_ADD_OP = 4'h0;

  typedef enum logic [1:0] {
    A_SEL_RS1      = 2'd0,
    A_SEL_PC       = 2'd1,
    A_SEL_ZERO     = 2'd2,
    A_SEL_ZERO_ALT = 2'd3
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [EX_XLEN-1:0]   pc;
    logic [EX_REG_AW-1:0] rs1_addr;
    logic [EX_REG_AW-1:0] rs2_addr;
    logic [EX_XLEN-1:0]   rs1_data;
    logic [EX_XLEN-1:0]   rs2_data;
    logic [EX_XLEN-1:0]   imm;
    a_sel_e               a_sel;
    b_sel_e               b_sel;
    logic [3:0]           alu_op;
    logic [EX_REG_AW-1:0] rd_addr;
    logic                 rd_wren;
    logic                 is_load;
  } id_ex_t;

  // A bubble writes nothing, so it can never be picked as a forwarding source.
  localparam id_ex_t ID_EX_BUBBLE = '{
    pc:       '0,
    rs1_addr: '0,
    rs2_addr: '0,
    rs1_data: '0,
    rs2_data: '0,
    imm:      '0,
    a_sel:    A_SEL_RS1,
    b_sel:    B_SEL_RS2,
    alu_op:   ALU_ADD_OP,
    rd_addr:  '0,
    rd_wren:  1'b0,
    is_load:  1'b0
  };

  // True when a used, non-x0 source register is written by the given producer.
  function automatic logic src_match(input logic [EX_REG_AW-1:0] src,
                                     input logic                 used,
                                     input logic [EX_REG_AW-1:0] rd,
                                     input logic                 wren);
    return used && (src != '0) && wren && (src == rd);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: x0 always reads the regfile, a MEM-stage
// producer wins over a WB-stage producer, otherwise the regfile data is used.
module fwd_mux import ex_operand_stage_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic              mem_rd_wren_i,
  input  logic [XLEN-1:0]   mem_fwd_data_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic              wb_rd_wren_i,
  input  logic [XLEN-1:0]   wb_fwd_data_i,
  output logic [XLEN-1:0]   data_o
);

  fwd_sel_e fwd_sel;

  // Pick the youngest producer of this source register.
  always_comb begin
    fwd_sel = FWD_RF;
    if (src_addr_i != '0) begin
      if (mem_rd_wren_i && (mem_rd_addr_i == src_addr_i)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_rd_wren_i && (wb_rd_addr_i == src_addr_i)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

  // Steer the selected source onto the operand.
  always_comb begin
    data_o = rf_data_i;
    case (fwd_sel)
      FWD_MEM: data_o = mem_fwd_data_i;
      FWD_WB:  data_o = wb_fwd_data_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and hazard handling.
// Define OPERAND_FWD_EN to enable MEM/WB forwarding (only load-use stalls);
// without it operands come straight from the latched regfile data and any
// RAW dependence on EX, MEM or WB stalls decode until the producer retires.
module ex_operand_stage import ex_operand_stage_pkg::*; #(
  parameter int XLEN   = EX_XLEN,
  parameter int REG_AW = EX_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [1:0]        id_a_sel_i,
  input  logic              id_b_sel_i,
  input  logic [3:0]        id_alu_op_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_rd_wren_i,
  input  logic              id_is_load_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic              mem_rd_wren_i,
  input  logic [XLEN-1:0]   mem_fwd_data_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic              wb_rd_wren_i,
  input  logic [XLEN-1:0]   wb_fwd_data_i,
  output logic              ex_valid_o,
  output logic [3:0]        alu_op_o,
  output logic [XLEN-1:0]   operand_a_o,
  output logic [XLEN-1:0]   operand_b_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_rd_wren_o,
  output logic              ex_is_load_o
);

`ifdef OPERAND_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  slot_state_e      state_q, state_d;
  id_ex_t           ex_q, ex_d;
  logic             hazard;
  logic [XLEN-1:0]  rs1_fwd;
  logic [XLEN-1:0]  rs2_fwd;

`ifdef OPERAND_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard = id_valid_i && ex_q.is_load &&
             (src_match(id_rs1_addr_i, id_rs1_used_i, ex_q.rd_addr, ex_q.rd_wren) ||
              src_match(id_rs2_addr_i, id_rs2_used_i, ex_q.rd_addr, ex_q.rd_wren));
  end
`else
  // Without bypassing, any in-flight writer of a used source blocks decode.
  always_comb begin
    hazard = id_valid_i &&
             (src_match(id_rs1_addr_i, id_rs1_used_i, ex_q.rd_addr, ex_q.rd_wren)   ||
              src_match(id_rs1_addr_i, id_rs1_used_i, mem_rd_addr_i, mem_rd_wren_i) ||
              src_match(id_rs1_addr_i, id_rs1_used_i, wb_rd_addr_i, wb_rd_wren_i)   ||
              src_match(id_rs2_addr_i, id_rs2_used_i, ex_q.rd_addr, ex_q.rd_wren)   ||
              src_match(id_rs2_addr_i, id_rs2_used_i, mem_rd_addr_i, mem_rd_wren_i) ||
              src_match(id_rs2_addr_i, id_rs2_used_i, wb_rd_addr_i, wb_rd_wren_i));
  end
`endif

  assign id_ready_o = !mem_stall_i && !hazard;

  // Slot update: flush kills first, a downstream stall freezes, else capture or bubble.
  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    if (flush_i) begin
      state_d = SLOT_EMPTY;
      ex_d    = ID_EX_BUBBLE;
    end else if (!mem_stall_i) begin
      if (id_valid_i && !hazard) begin
        state_d = SLOT_FULL;
        ex_d    = '{
          pc:       id_pc_i,
          rs1_addr: id_rs1_addr_i,
          rs2_addr: id_rs2_addr_i,
          rs1_data: id_rs1_data_i,
          rs2_data: id_rs2_data_i,
          imm:      id_imm_i,
          a_sel:    a_sel_e'(id_a_sel_i),
          b_sel:    b_sel_e'(id_b_sel_i),
          alu_op:   id_alu_op_i,
          rd_addr:  id_rd_addr_i,
          rd_wren:  id_rd_wren_i,
          is_load:  id_is_load_i
        };
      end else begin
        state_d = SLOT_EMPTY;
        ex_d    = ID_EX_BUBBLE;
      end
    end
  end

  // EX slot register; reset leaves an empty slot that drives an ADD of zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      ex_q    <= ID_EX_BUBBLE;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src_addr_i     (ex_q.rs1_addr),
    .rf_data_i      (ex_q.rs1_data),
    .mem_rd_addr_i  (mem_rd_addr_i),
    .mem_rd_wren_i  (mem_rd_wren_i & FWD_EN),
    .mem_fwd_data_i (mem_fwd_data_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .wb_rd_wren_i   (wb_rd_wren_i & FWD_EN),
    .wb_fwd_data_i  (wb_fwd_data_i),
    .data_o         (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src_addr_i     (ex_q.rs2_addr),
    .rf_data_i      (ex_q.rs2_data),
    .mem_rd_addr_i  (mem_rd_addr_i),
    .mem_rd_wren_i  (mem_rd_wren_i & FWD_EN),
    .mem_fwd_data_i (mem_fwd_data_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .wb_rd_wren_i   (wb_rd_wren_i & FWD_EN),
    .wb_fwd_data_i  (wb_fwd_data_i),
    .data_o         (rs2_fwd)
  );

  // ALU operand A: forwarded rs1, the PC, or zero.
  always_comb begin
    operand_a_o = '0;
    case (ex_q.a_sel)
      A_SEL_RS1: operand_a_o = rs1_fwd;
      A_SEL_PC:  operand_a_o = ex_q.pc;
      default:   operand_a_o = '0;
    endcase
  end

  // ALU operand B: forwarded rs2 or the immediate.
  always_comb begin
    operand_b_o = rs2_fwd;
    if (ex_q.b_sel == B_SEL_IMM) begin
      operand_b_o = ex_q.imm;
    end
  end

  assign store_data_o = rs2_fwd;
  assign ex_valid_o   = (state_q == SLOT_FULL);
  assign alu_op_o     = ex_q.alu_op;
  assign ex_rd_addr_o = ex_q.rd_addr;
  assign ex_rd_wren_o = ex_q.rd_wren;
  assign ex_is_load_o = ex_q.is_load;

endmodule
